response_tx: RTL and testbench

- Bit-serial transmitter, FPGA -> MBED; the return path of the MBED instruction link.
- Takes a parallel status/response word from the servo control logic and shifts it out MSB first.
- One data line plus one strobe line, with a full four-phase req/ack handshake per bit against an MBED acknowledge line.
- Raises done when the frame completes; flags timeout if MBED stops acknowledging.

---
 rtl/response_tx.sv | 194 +++++++++++++++++++
 tb/tb_response_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/response_tx.sv
// Bit-serial response transmitter (FPGA -> MBED): shifts a word out MSB first with a four-phase strobe/ack handshake per bit.
// Optional macro RESPONSE_TX_PARITY_EN appends one even-parity bit to every frame.
module response_tx #(
    parameter int unsigned WIDTH          = 10,
    parameter int unsigned SETUP_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             mbed_ack,
    output logic             tx_bit,
    output logic             tx_strobe,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

`ifdef RESPONSE_TX_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif
    localparam int unsigned BIT_W = $clog2(NBITS) + 1;
    localparam int unsigned SET_W = $clog2(SETUP_CYCLES) + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(NBITS - 1);
    localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETUP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_HI,
        S_WAIT_LO,
        S_FINISH,
        S_ABORT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               tx_bit_q, tx_bit_d;
    logic               strobe_q, strobe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               ack_meta_q, ack_s_q;
    logic               fill_c;

`ifdef RESPONSE_TX_PARITY_EN
    logic parity_q, parity_d;

    // Parity enters the shift LSB on the first shift and reaches the MSB exactly after the last data bit.
    assign fill_c = parity_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    always_comb begin
        parity_d = parity_q;
        if (state_q == S_IDLE && load) begin
            parity_d = ^data_in;
        end
    end
`else
    assign fill_c = 1'b0;
`endif

    // State, datapath and output registers; ack passes through a 2-FF synchroniser.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            set_cnt_q  <= '0;
            to_cnt_q   <= '0;
            tx_bit_q   <= 1'b0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            set_cnt_q  <= set_cnt_d;
            to_cnt_q   <= to_cnt_d;
            tx_bit_q   <= tx_bit_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            ack_meta_q <= mbed_ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        set_cnt_d = set_cnt_q;
        to_cnt_d  = to_cnt_q;
        tx_bit_d  = tx_bit_q;
        strobe_d  = strobe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d   = S_SETUP;
                    shift_d   = data_in;
                    bit_cnt_d = '0;
                    set_cnt_d = '0;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    tx_bit_d  = data_in[WIDTH-1];
                end
            end
            S_SETUP: begin
                if (set_cnt_q == SET_LAST) begin
                    strobe_d = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_WAIT_HI;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            S_WAIT_HI: begin
                if (ack_s_q) begin
                    strobe_d = 1'b0;
                    to_cnt_d = '0;
                    state_d  = S_WAIT_LO;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d   = S_ABORT;
                    strobe_d  = 1'b0;
                    tx_bit_d  = 1'b0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_WAIT_LO: begin
                if (!ack_s_q) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d  = S_FINISH;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        tx_bit_d = 1'b0;
                    end else begin
                        shift_d   = WIDTH'({shift_q, fill_c});
                        tx_bit_d  = shift_d[WIDTH-1];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        set_cnt_d = '0;
                        state_d   = S_SETUP;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d   = S_ABORT;
                    strobe_d  = 1'b0;
                    tx_bit_d  = 1'b0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_ABORT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign tx_bit    = tx_bit_q;
    assign tx_strobe = strobe_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_response_tx.sv
// Self-checking bench for response_tx: an MBED responder model, a strobe monitor and a frame-level reference model.
module tb_response_tx;
    localparam int unsigned WIDTH          = 10;
    localparam int unsigned SETUP_CYCLES   = 4;
    localparam int unsigned TIMEOUT_CYCLES = 16;
`ifdef RESPONSE_TX_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             clear = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             mbed_ack = 1'b0;
    logic             tx_bit, tx_strobe, busy, done, timeout;

    int errors = 0;
    int checks = 0;

    // Responder: 0 = ack follows strobe after ack_delay cycles, 1 = silent, 2 = stuck high.
    int ack_mode = 0;
    int ack_delay = 0;
    int ack_wait = 0;

    int          strobe_cnt = 0, done_cnt = 0, stab_err = 0, hi_len = 0, max_hi = 0;
    logic [15:0] cap = '0;
    logic        prev_strobe = 1'b0, prev_bit = 1'b0, rise_bit = 1'b0;

    response_tx #(
        .WIDTH(WIDTH),
        .SETUP_CYCLES(SETUP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .clear(clear),
        .load(load),
        .data_in(data_in),
        .mbed_ack(mbed_ack),
        .tx_bit(tx_bit),
        .tx_strobe(tx_strobe),
        .busy(busy),
        .done(done),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack_mode == 1) mbed_ack = 1'b0;
        else if (ack_mode == 2) mbed_ack = 1'b1;
        else if (tx_strobe != mbed_ack) begin
            if (ack_wait >= ack_delay) begin
                mbed_ack = tx_strobe;
                ack_wait = 0;
            end else ack_wait = ack_wait + 1;
        end else ack_wait = 0;
    end

    // Monitor: sample bit at each strobe rise, check data stability around the strobe.
    always @(negedge clk) begin
        if (tx_strobe && !prev_strobe) begin
            strobe_cnt = strobe_cnt + 1;
            cap = {cap[14:0], tx_bit};
            rise_bit = tx_bit;
            hi_len = 0;
            if (tx_bit !== prev_bit) stab_err = stab_err + 1;
        end
        if (tx_strobe) begin
            if (tx_bit !== rise_bit) stab_err = stab_err + 1;
            hi_len = hi_len + 1;
            if (hi_len > max_hi) max_hi = hi_len;
        end
        if (done) done_cnt = done_cnt + 1;
        if (done && busy) stab_err = stab_err + 1;
        prev_strobe = tx_strobe;
        prev_bit = tx_bit;
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks = checks + 1;
        if (act < lo || act > hi) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference: first n bits of the frame (data MSB first, then even parity), packed MSB first.
    function automatic int model_bits(input logic [WIDTH-1:0] d, input int n);
        int acc = 0;
        int b;
        for (int i = 0; i < n; i++) begin
            if (i < int'(WIDTH)) b = (int'(d) >> (int'(WIDTH) - 1 - i)) & 1;
            else b = $countones(d) % 2;
            acc = acc * 2 + b;
        end
        return acc;
    endfunction

    task automatic start_frame(input logic [WIDTH-1:0] d, input int mode, input int dly);
        @(posedge clk);
        ack_mode = mode;
        ack_delay = dly;
        repeat (12) @(posedge clk);
        #1;
        strobe_cnt = 0; done_cnt = 0; stab_err = 0; max_hi = 0; cap = '0;
        @(negedge clk);
        load = 1'b1;
        data_in = d;
        @(negedge clk);
        load = 1'b0;
        data_in = WIDTH'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({name, "_busy_fall"}, 1, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string name, input logic [WIDTH-1:0] d,
                               input int exp_strobes, input int exp_done, input int exp_to);
        check({name, "_strobes"}, strobe_cnt, exp_strobes);
        check({name, "_bits"}, int'(cap), model_bits(d, exp_strobes));
        check({name, "_done"}, done_cnt, exp_done);
        check({name, "_timeout"}, int'(timeout), exp_to);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_stable"}, stab_err, 0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_tx_bit"}, int'(tx_bit), 0);
        check({name, "_tx_strobe"}, int'(tx_strobe), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_done"}, int'(done), 0);
        check({name, "_timeout"}, int'(timeout), 0);
    endtask

    typedef struct {
        logic [WIDTH-1:0] data;
        int mode;
        int dly;
        int exp_strobes;
        int exp_done;
        int exp_to;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int n;
        int base;
        logic [WIDTH-1:0] rd;

        vecs[0] = '{10'b1011001110, 0, 3, NB, 1, 0};
        vecs[1] = '{10'h155, 1, 0, 1, 0, 1};
        vecs[2] = '{10'h155, 0, 3, NB, 1, 0};
        vecs[3] = '{10'h001, 0, 0, NB, 1, 0};
        vecs[4] = '{10'h003, 0, 1, NB, 1, 0};
        vecs[5] = '{10'h000, 0, 5, NB, 1, 0};
        vecs[6] = '{10'h3FF, 0, 2, NB, 1, 0};
        vecs[7] = '{10'h2AA, 2, 0, 1, 0, 1};
        vecs[8] = '{10'h2AA, 0, 1, NB, 1, 0};

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        clear = 1'b0;

        for (int i = 0; i < 9; i++) begin
            start_frame(vecs[i].data, vecs[i].mode, vecs[i].dly);
            wait_idle("vec");
            check_frame("vec", vecs[i].data, vecs[i].exp_strobes, vecs[i].exp_done, vecs[i].exp_to);
            if (vecs[i].mode == 1) check_range("silent_strobe_len", max_hi, TIMEOUT_CYCLES, TIMEOUT_CYCLES + 2);
            if (vecs[i].mode == 2) check_range("stuck_strobe_len", max_hi, 1, 3);
        end

        // Load while busy is ignored and does not queue a second frame.
        start_frame(10'h3FF, 0, 2);
        n = 0;
        while (strobe_cnt < 3 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("lockout_reach_bit3", int'(strobe_cnt >= 3), 1);
        @(negedge clk);
        load = 1'b1;
        data_in = 10'h000;
        @(negedge clk);
        load = 1'b0;
        wait_idle("lockout");
        check_frame("lockout", 10'h3FF, NB, 1, 0);
        base = strobe_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("lockout_no_second", strobe_cnt - base, 0);
        check("lockout_busy_after", int'(busy), 0);

        // Clear in WAIT_LO of the sixth bit, then a clean frame.
        start_frame(10'h155, 0, 3);
        n = 0;
        while (!(strobe_cnt == 6 && !tx_strobe) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("clear_reach_bit", int'(strobe_cnt == 6 && !tx_strobe), 1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_idle_outputs("clear");
        start_frame(10'h2AA, 0, 3);
        wait_idle("after_clear");
        check_frame("after_clear", 10'h2AA, NB, 1, 0);

        // Random words and ack latencies against the reference model.
        for (int k = 0; k < 12; k++) begin
            rd = WIDTH'($urandom);
            start_frame(rd, 0, int'($urandom_range(0, 4)));
            wait_idle("rand");
            check_frame("rand", rd, NB, 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
